// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the fetch unit: jump opcode, opcode field position and FSM encoding.
package unidade_busca_pkg;

  localparam logic [5:0] OP_JUMP = 6'b000101;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_t;

endpackage

// File: rtl/unidade_busca_detector_parada.sv
// Halt decode: a jump whose target is its own address stops the processor.
// Purely combinational, zero latency, no flow control.
module detector_parada
  import unidade_busca_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic [DATA_WIDTH-1:0] Instrucao,
  input  logic [ADDR_WIDTH-1:0] pc_d,
  output logic                  halt
);

  logic unused_campos;

  assign halt = (Instrucao[OPC_MSB:OPC_LSB] == OP_JUMP) &&
                (Instrucao[ADDR_WIDTH-1:0] == pc_d);

  assign unused_campos = ^Instrucao;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch: drives the memory address combinationally, data returns one cycle later.
// stall holds the presented word; desvio redirects with one cycle of latency and squashes the current word.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  desvio,
  input  logic [ADDR_WIDTH-1:0] alvo,
  input  logic [DATA_WIDTH-1:0] Instrucao,
  output logic [ADDR_WIDTH-1:0] Endereco,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  valido,
  output logic                  parado,
  output logic [31:0]           num_instr
);

  estado_t               state, next_state;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [31:0]           contador;
  logic                  halt;

  detector_parada #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_detector (
    .Instrucao(Instrucao),
    .pc_d     (pc_d),
    .halt     (halt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= INICIO;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INICIO:  next_state = BUSCA;
      BUSCA:   if (!desvio && !stall && halt) next_state = PARADO;
      PARADO:  next_state = PARADO;
      default: next_state = INICIO;
    endcase
  end

  always_comb begin
    Endereco = pc_d;
    valido   = 1'b0;
    parado   = 1'b0;
    if (reset) begin
      Endereco = '0;
    end else begin
      case (state)
        INICIO: Endereco = '0;
        BUSCA: begin
          if (desvio) begin
            Endereco = alvo;
          end else begin
            valido = 1'b1;
            if (!stall && !halt) Endereco = pc_d + 1'b1;
          end
        end
        PARADO:  parado = 1'b1;
        default: Endereco = '0;
      endcase
    end
  end

  // Endereco already encodes every pc_d transition, so pc_d simply tracks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d     <= '0;
      contador <= '0;
    end else begin
      pc_d <= Endereco;
      if (valido && !stall) contador <= contador + 32'd1;
    end
  end

  assign instr_out = Instrucao;
  assign pc_out    = pc_d;
  assign num_instr = contador;

endmodule
